// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill path: geometry, FSM encoding and
// requester identifiers used by the fill arbiter and its counters.
package cache_pkg;

    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_BYTES     = 2 * WORDS_PER_BLOCK;
    localparam int CNT_W           = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Aligns a byte address down to the start of its cache block.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(BLOCK_BYTES - 1);
    endfunction

endpackage

// File: rtl/word_counter.sv
// Small up-counter with synchronous clear and enable; tc flags the last
// word index so the owner can tell when a block's worth has been counted.
module word_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = &count;

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates write-through stores and I/D cache misses onto the pipelined
// main memory, streaming one block of reads per miss back into the cache.
module cache_fill_arbiter
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_miss_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_miss_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [DATA_W-1:0] fill_data,
    output logic [CNT_W-1:0]  fill_word,
    output logic              icache_data_we,
    output logic              dcache_data_we,
    output logic              icache_tag_we,
    output logic              dcache_tag_we,
    output logic              icache_fill_done,
    output logic              dcache_fill_done,
    output logic              busy
);

    state_t            state;
    state_t            next_state;
    logic              req_side;
    logic [ADDR_W-1:0] base_addr;
    logic              issue_done;

    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              issue_tc;
    logic              recv_tc;
    logic              issue_en;
    logic              recv_en;
    logic              cnt_clr;

    logic              grant_d;
    logic [ADDR_W-1:0] grant_addr;

    word_counter #(.W(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (issue_en),
        .count (issue_cnt),
        .tc    (issue_tc)
    );

    word_counter #(.W(CNT_W)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (recv_en),
        .count (recv_cnt),
        .tc    (recv_tc)
    );

    // Among misses the D side wins; stores are handled ahead of both in IDLE.
    always_comb begin
        grant_d    = dcache_miss;
        grant_addr = dcache_miss ? dcache_miss_addr : icache_miss_addr;
    end

    // Requester and block base are frozen at FILL entry so later changes on
    // the miss inputs cannot disturb a refill in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_side   <= REQ_I;
            base_addr  <= '0;
            issue_done <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && next_state == ST_FILL) begin
                req_side  <= grant_d ? REQ_D : REQ_I;
                base_addr <= block_base(grant_addr);
            end
            if (state != ST_FILL) begin
                issue_done <= 1'b0;
            end else if (issue_en && issue_tc) begin
                issue_done <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state       = state;
        cnt_clr          = 1'b1;
        issue_en         = 1'b0;
        recv_en          = 1'b0;
        wr_ack           = 1'b0;
        mem_en           = 1'b0;
        mem_wr           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        fill_data        = '0;
        fill_word        = '0;
        icache_data_we   = 1'b0;
        dcache_data_we   = 1'b0;
        icache_tag_we    = 1'b0;
        dcache_tag_we    = 1'b0;
        icache_fill_done = 1'b0;
        dcache_fill_done = 1'b0;
        busy             = 1'b0;

        case (state)
            ST_IDLE: begin
                if (wr_req) begin
                    next_state = ST_WRITE;
                end else if (dcache_miss || icache_miss) begin
                    next_state = ST_FILL;
                end
            end

            ST_WRITE: begin
                busy       = 1'b1;
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = wr_addr;
                mem_wdata  = wr_data;
                wr_ack     = 1'b1;
                next_state = ST_IDLE;
            end

            // Reads stream out back to back while returning words are steered
            // into whichever cache missed; the last word also closes the fill.
            ST_FILL: begin
                busy     = 1'b1;
                cnt_clr  = 1'b0;
                issue_en = !issue_done;
                if (issue_en) begin
                    mem_en   = 1'b1;
                    mem_addr = base_addr + (ADDR_W'(issue_cnt) << 1);
                end
                if (mem_rvalid) begin
                    recv_en   = 1'b1;
                    fill_data = mem_rdata;
                    fill_word = recv_cnt;
                    if (req_side == REQ_D) begin
                        dcache_data_we = 1'b1;
                    end else begin
                        icache_data_we = 1'b1;
                    end
                    if (recv_tc) begin
                        if (req_side == REQ_D) begin
                            dcache_tag_we    = 1'b1;
                            dcache_fill_done = 1'b1;
                        end else begin
                            icache_tag_we    = 1'b1;
                            icache_fill_done = 1'b1;
                        end
                        next_state = ST_IDLE;
                    end
                end
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: a latency-4 pipelined memory plus a
// transaction-level model that predicts every cycle of each store and refill.
module tb_cache_fill_arbiter;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icache_miss = 1'b0;
    logic [15:0] icache_miss_addr = '0;
    logic        dcache_miss = 1'b0;
    logic [15:0] dcache_miss_addr = '0;
    logic        wr_req = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        icache_data_we;
    logic        dcache_data_we;
    logic        icache_tag_we;
    logic        dcache_tag_we;
    logic        icache_fill_done;
    logic        dcache_fill_done;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    int          cyc = 0;
    int          m_kind = 0;
    int          m_start = 0;
    int          m_earliest = 0;
    logic [15:0] m_base = '0;
    logic [15:0] m_waddr = '0;
    logic [15:0] m_wdata = '0;

    logic [3:0]  pipe_v = '0;
    logic [15:0] pipe_d [4];

    always #5 clk = ~clk;

    cache_fill_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .icache_miss      (icache_miss),
        .icache_miss_addr (icache_miss_addr),
        .dcache_miss      (dcache_miss),
        .dcache_miss_addr (dcache_miss_addr),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_ack           (wr_ack),
        .mem_en           (mem_en),
        .mem_wr           (mem_wr),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_rvalid       (mem_rvalid),
        .fill_data        (fill_data),
        .fill_word        (fill_word),
        .icache_data_we   (icache_data_we),
        .dcache_data_we   (dcache_data_we),
        .icache_tag_we    (icache_tag_we),
        .dcache_tag_we    (dcache_tag_we),
        .icache_fill_done (icache_fill_done),
        .dcache_fill_done (dcache_fill_done),
        .busy             (busy)
    );

    // Memory answers a read issued in cycle t during cycle t+4, data = addr ^ A5A5.
    always @(posedge clk) begin
        if (!rst_n) begin
            pipe_v <= '0;
        end else begin
            pipe_v    <= {pipe_v[2:0], mem_en & ~mem_wr};
            pipe_d[0] <= mem_addr ^ 16'hA5A5;
            pipe_d[1] <= pipe_d[0];
            pipe_d[2] <= pipe_d[1];
            pipe_d[3] <= pipe_d[2];
        end
    end

    assign mem_rvalid = pipe_v[3];
    assign mem_rdata  = pipe_d[3];

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One negedge of checking: the model decides what the DUT must show now.
    task automatic sample_cycle();
        int k;
        int j;
        logic is_d;
        logic rx;
        logic fin;
        logic any_we;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
        cyc++;
        if (!rst_n) begin
            m_kind     = 0;
            m_earliest = cyc + 1;
            check_output("reset_outputs",
                64'({wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
                     icache_data_we, dcache_data_we, icache_tag_we, dcache_tag_we,
                     icache_fill_done, dcache_fill_done, busy}), 64'(0));
            return;
        end
        if (m_kind == 0) begin
            if (cyc >= m_earliest && (wr_req || dcache_miss || icache_miss)) begin
                m_start = cyc;
                if (wr_req) begin
                    m_kind  = 1;
                    m_waddr = wr_addr;
                    m_wdata = wr_data;
                end else if (dcache_miss) begin
                    m_kind = 2;
                    m_base = dcache_miss_addr & 16'hFFF0;
                end else begin
                    m_kind = 3;
                    m_base = icache_miss_addr & 16'hFFF0;
                end
            end else begin
                check_output("idle_ctrl",
                    64'({busy, mem_en, wr_ack, icache_data_we, dcache_data_we, icache_tag_we,
                         dcache_tag_we, icache_fill_done, dcache_fill_done}), 64'(0));
                return;
            end
        end
        if (m_kind == 1) begin
            check_output("write",
                64'({wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, busy, icache_data_we, dcache_data_we}),
                64'({1'b1, 1'b1, 1'b1, m_waddr, m_wdata, 1'b1, 1'b0, 1'b0}));
            wr_req     = 1'b0;
            m_kind     = 0;
            m_earliest = cyc + 2;
        end else begin
            k        = cyc - m_start;
            is_d     = (m_kind == 2);
            exp_addr = m_base + 16'(2 * k);
            check_output("fill_issue",
                64'({mem_en, mem_wr, (k < 8) ? mem_addr : 16'h0}),
                64'({(k < 8), 1'b0, (k < 8) ? exp_addr : 16'h0}));
            rx       = (k >= 4) && (k < 12);
            j        = k - 4;
            exp_data = (m_base + 16'(2 * j)) ^ 16'hA5A5;
            any_we   = icache_data_we | dcache_data_we;
            check_output("fill_recv",
                64'({icache_data_we, dcache_data_we, any_we ? fill_word : 3'd0, any_we ? fill_data : 16'h0}),
                64'({rx && !is_d, rx && is_d, rx ? 3'(j) : 3'd0, rx ? exp_data : 16'h0}));
            fin = (k == 11);
            check_output("fill_done",
                64'({icache_tag_we, dcache_tag_we, icache_fill_done, dcache_fill_done, busy, wr_ack}),
                64'({fin && !is_d, fin && is_d, fin && !is_d, fin && is_d, 1'b1, 1'b0}));
            if (fin) begin
                if (is_d) dcache_miss = 1'b0;
                else      icache_miss = 1'b0;
                m_kind     = 0;
                m_earliest = cyc + 2;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample_cycle();
    endtask

    task automatic apply_stimulus(input logic do_w, input logic [15:0] wa, input logic [15:0] wd,
                                  input logic do_d, input logic [15:0] da,
                                  input logic do_i, input logic [15:0] ia);
        if (do_w && !wr_req) begin
            wr_req  = 1'b1;
            wr_addr = wa;
            wr_data = wd;
        end
        if (do_d && !dcache_miss) begin
            dcache_miss      = 1'b1;
            dcache_miss_addr = da;
        end
        if (do_i && !icache_miss) begin
            icache_miss      = 1'b1;
            icache_miss_addr = ia;
        end
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        logic timed_out;
        while ((wr_req || dcache_miss || icache_miss || m_kind != 0) && n < max_cycles) begin
            step();
            n++;
        end
        timed_out = (n >= max_cycles);
        check_output("drain_timeout", 64'(timed_out), 64'(0));
        repeat (2) step();
    endtask

    task automatic wait_phase(input int kind, input int k, input int max_cycles);
        int n = 0;
        logic timed_out;
        while (!(m_kind == kind && cyc - m_start == k) && n < max_cycles) begin
            step();
            n++;
        end
        timed_out = (n >= max_cycles);
        check_output("phase_timeout", 64'(timed_out), 64'(0));
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        step();

        $display("[TB] single I-side refill at 0x0036");
        apply_stimulus(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0036);
        drain(100);

        $display("[TB] simultaneous I and D misses");
        apply_stimulus(1'b0, 16'h0, 16'h0, 1'b1, 16'h2008, 1'b1, 16'h1000);
        drain(100);

        $display("[TB] store alongside D miss");
        apply_stimulus(1'b1, 16'h0040, 16'hBEEF, 1'b1, 16'h0080, 1'b0, 16'h0);
        drain(100);

        $display("[TB] store arriving during a fill");
        apply_stimulus(1'b0, 16'h0, 16'h0, 1'b1, 16'h0104, 1'b0, 16'h0);
        wait_phase(2, 2, 20);
        apply_stimulus(1'b1, 16'h0050, 16'h1234, 1'b0, 16'h0, 1'b0, 16'h0);
        drain(100);

        $display("[TB] reset in the middle of a fill");
        apply_stimulus(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0206);
        wait_phase(3, 8, 30);
        rst_n       = 1'b0;
        icache_miss = 1'b0;
        step();
        rst_n       = 1'b1;
        icache_miss = 1'b1;
        drain(100);

        $display("[TB] miss at top of address space");
        apply_stimulus(1'b0, 16'h0, 16'h0, 1'b1, 16'hFFFE, 1'b0, 16'h0);
        drain(100);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 60; it++) begin
            apply_stimulus($urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom),
                           $urandom_range(0, 3) == 0, 16'($urandom),
                           $urandom_range(0, 3) == 0, 16'($urandom));
            repeat ($urandom_range(0, 12)) step();
        end
        drain(3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
